// File: rtl/exec_unit.sv
// Integer execution unit: single-cycle ALU ops plus iterative multiply/divide
// writing a HI/LO register pair, with a valid/ready handshake and flush.
module exec_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   hi_reg, lo_reg, result_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   opnd_reg, dividend_reg;
    logic [SHW-1:0]     cnt_reg;
    logic               is_div_reg, neg_q_reg, neg_r_reg, div_zero_reg;

    logic             accept, is_multi, op_div, op_signed, neg1, neg2, last_step;
    logic [WIDTH-1:0] mag1, mag2, alu_res;
    logic [SHW-1:0]   shamt;

    assign accept    = in_valid && (state_reg == IDLE) && !flush;
    assign is_multi  = (op[4:2] == 3'b100);
    assign op_div    = op[1];
    assign op_signed = !op[0];
    assign neg1      = op_signed && src1[WIDTH-1];
    assign neg2      = op_signed && src2[WIDTH-1];
    assign mag1      = neg1 ? -src1 : src1;
    assign mag2      = neg2 ? -src2 : src2;
    assign shamt     = src1[SHW-1:0];
    assign last_step = (cnt_reg == LAST);

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign result    = result_reg;

    always_comb begin
        alu_res = '0;
        case (op)
            5'd0:  alu_res = src1 + src2;
            5'd1:  alu_res = src1 - src2;
            5'd2:  alu_res = src1 & src2;
            5'd3:  alu_res = src1 | src2;
            5'd4:  alu_res = ~(src1 | src2);
            5'd5:  alu_res = src1 ^ src2;
            5'd6:  alu_res = src2 << shamt;
            5'd7:  alu_res = WIDTH'($signed(src2) >>> shamt);
            5'd8:  alu_res = src2 >> shamt;
            5'd9:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src1) < $signed(src2))};
            5'd10: alu_res = {{(WIDTH-1){1'b0}}, (src1 < src2)};
            5'd15: alu_res = src2;
            5'd20: alu_res = hi_reg;
            5'd21: alu_res = lo_reg;
            5'd22: alu_res = src1;
            5'd23: alu_res = src1;
            default: alu_res = '0;
        endcase
    end

    // One iteration of each algorithm; acc holds {partial hi, shifting lo} for
    // multiply and {remainder, shifting dividend/quotient} for divide.
    logic [WIDTH:0]     mul_sum, div_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_next;
    logic [2*WIDTH-1:0] mul_next, div_next, step_next, prod;
    logic [WIDTH-1:0]   quot_fix, rem_fix, fin_hi, fin_lo;

    always_comb begin
        mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, (acc_reg[0] ? opnd_reg : '0)};
        mul_next  = {mul_sum, acc_reg[WIDTH-1:1]};
        div_sh    = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
        div_ge    = (div_sh >= {1'b0, opnd_reg});
        rem_next  = div_ge ? (div_sh[WIDTH-1:0] - opnd_reg) : div_sh[WIDTH-1:0];
        div_next  = {rem_next, acc_reg[WIDTH-2:0], div_ge};
        step_next = is_div_reg ? div_next : mul_next;

        prod      = neg_q_reg ? -step_next : step_next;
        quot_fix  = neg_q_reg ? -step_next[WIDTH-1:0] : step_next[WIDTH-1:0];
        rem_fix   = neg_r_reg ? -step_next[2*WIDTH-1:WIDTH] : step_next[2*WIDTH-1:WIDTH];

        fin_hi = prod[2*WIDTH-1:WIDTH];
        fin_lo = prod[WIDTH-1:0];
        if (is_div_reg) begin
            if (div_zero_reg) begin
                fin_hi = dividend_reg;
                fin_lo = '1;
            end else begin
                fin_hi = rem_fix;
                fin_lo = quot_fix;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = is_multi ? BUSY : DONE;
            BUSY: begin
                if (flush)          state_next = IDLE;
                else if (last_step) state_next = DONE;
            end
            DONE: if (flush || out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_reg       <= '0;
            lo_reg       <= '0;
            result_reg   <= '0;
            acc_reg      <= '0;
            opnd_reg     <= '0;
            dividend_reg <= '0;
            cnt_reg      <= '0;
            is_div_reg   <= 1'b0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
        end else if (accept) begin
            cnt_reg <= '0;
            if (is_multi) begin
                // Both algorithms run on magnitudes; signs are reapplied at the end.
                acc_reg      <= {{WIDTH{1'b0}}, (op_div ? mag1 : mag2)};
                opnd_reg     <= op_div ? mag2 : mag1;
                dividend_reg <= src1;
                is_div_reg   <= op_div;
                neg_q_reg    <= neg1 ^ neg2;
                neg_r_reg    <= neg1;
                div_zero_reg <= (src2 == '0);
            end else begin
                result_reg <= alu_res;
                if (op == 5'd22) hi_reg <= src1;
                if (op == 5'd23) lo_reg <= src1;
            end
        end else if (state_reg == BUSY && !flush) begin
            acc_reg <= step_next;
            cnt_reg <= cnt_reg + 1'b1;
            if (last_step) begin
                hi_reg     <= fin_hi;
                lo_reg     <= fin_lo;
                result_reg <= fin_lo;
            end
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Randomized and directed bench for exec_unit against an arithmetic reference
// model tracking HI/LO; a second 8-bit instance covers the narrow configuration.
module tb_exec_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [4:0]  op;
    logic [31:0] src1, src2, result;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [4:0]  op8;
    logic [7:0]  src1_8, src2_8, result8;

    always #5 clk = ~clk;

    exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .src1(src1), .src2(src2), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    exec_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid8), .in_ready(in_ready8),
        .op(op8), .src1(src1_8), .src2(src2_8), .flush(1'b0),
        .out_valid(out_valid8), .out_ready(out_ready8), .result(result8)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour from the operation definitions, using wide arithmetic.
    task automatic model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r);
        longint      sa, sb, t;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        case (o)
            5'd0:  r = a + b;
            5'd1:  r = a - b;
            5'd2:  r = a & b;
            5'd3:  r = a | b;
            5'd4:  r = ~(a | b);
            5'd5:  r = a ^ b;
            5'd6:  r = b << a[4:0];
            5'd7:  begin t = sb >>> a[4:0]; r = t[31:0]; end
            5'd8:  r = b >> a[4:0];
            5'd9:  r = (sa < sb) ? 32'd1 : 32'd0;
            5'd10: r = (a < b) ? 32'd1 : 32'd0;
            5'd15: r = b;
            5'd16: begin t = sa * sb; p = t; {m_hi, m_lo} = p; r = m_lo; end
            5'd17: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = p; r = m_lo; end
            5'd18: begin
                if (b == 0) begin m_lo = '1; m_hi = a; end
                else begin
                    t = sa / sb; m_lo = t[31:0];
                    t = sa % sb; m_hi = t[31:0];
                end
                r = m_lo;
            end
            5'd19: begin
                if (b == 0) begin m_lo = '1; m_hi = a; end
                else begin m_lo = a / b; m_hi = a % b; end
                r = m_lo;
            end
            5'd20: r = m_hi;
            5'd21: r = m_lo;
            5'd22: begin m_hi = a; r = a; end
            5'd23: begin m_lo = a; r = a; end
            default: r = '0;
        endcase
    endtask

    task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output int lat);
        @(negedge clk);
        check("ready_before_accept", in_ready, 1);
        in_valid = 1'b1; op = o; src1 = a; src2 = b;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        r = result;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic exec_check(input string tag, input logic [4:0] o,
                              input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp, r;
        int          lat;
        model(o, a, b, exp);
        run_op(o, a, b, r, lat);
        check(tag, r, exp);
        check({tag, "_latency"}, lat, (o >= 5'd16 && o <= 5'd19) ? 33 : 1);
        $display("op=%0d src1=0x%08h src2=0x%08h result=0x%08h latency=%0d", o, a, b, r, lat);
    endtask

    task automatic run_op8(input logic [4:0] o, input logic [7:0] a, input logic [7:0] b,
                           output logic [7:0] r, output int lat);
        @(negedge clk);
        in_valid8 = 1'b1; op8 = o; src1_8 = a; src2_8 = b;
        @(negedge clk);
        in_valid8 = 1'b0;
        lat = 1;
        while (!out_valid8 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        r = result8;
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, a, b;
        logic [7:0]  r8;
        logic [4:0]  o;
        int          lat, seen;

        resetn = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        op = '0; src1 = '0; src2 = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; op8 = '0; src1_8 = '0; src2_8 = '0;
        #2;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_result", result, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        exec_check("sub", 5'd1, 32'd5, 32'd7);
        exec_check("sra", 5'd7, 32'h24, 32'h8000_0000);
        exec_check("mult", 5'd16, 32'hFFFF_FFFF, 32'd3);
        exec_check("mfhi_mult", 5'd20, 32'd0, 32'd0);
        exec_check("mflo_mult", 5'd21, 32'd0, 32'd0);
        exec_check("div", 5'd18, 32'hFFFF_FFF9, 32'd2);
        exec_check("mfhi_div", 5'd20, 32'd0, 32'd0);
        exec_check("divu_zero", 5'd19, 32'd9, 32'd0);
        exec_check("mfhi_divu_zero", 5'd20, 32'd0, 32'd0);
        exec_check("div_zero_signed", 5'd18, 32'hFFFF_FFF0, 32'd0);
        exec_check("mfhi_div_zero", 5'd20, 32'd0, 32'd0);
        exec_check("div_ovf", 5'd18, 32'h8000_0000, 32'hFFFF_FFFF);
        exec_check("mfhi_div_ovf", 5'd20, 32'd0, 32'd0);
        exec_check("mthi", 5'd22, 32'hAAAA_5555, 32'd0);
        exec_check("mtlo", 5'd23, 32'h0000_1234, 32'd0);

        // Flush in BUSY cycle 10 of a divide: back to IDLE, HI/LO untouched.
        @(negedge clk);
        in_valid = 1'b1; op = 5'd18; src1 = 32'd100; src2 = 32'd7;
        @(negedge clk);
        in_valid = 1'b0;
        seen = 0;
        for (int i = 1; i < 10; i++) begin
            if (out_valid) seen = 1;
            @(negedge clk);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy_ready", in_ready, 1);
        check("flush_busy_no_valid", out_valid | seen[0], 0);
        exec_check("mfhi_after_flush", 5'd20, 32'd0, 32'd0);
        exec_check("mflo_after_flush", 5'd21, 32'd0, 32'd0);

        // Flush coinciding with the final multiply iteration wins over completion.
        @(negedge clk);
        in_valid = 1'b1; op = 5'd17; src1 = 32'h1234_5678; src2 = 32'h9ABC_DEF0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (31) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_last_no_valid", out_valid, 0);
        exec_check("mfhi_after_late_flush", 5'd20, 32'd0, 32'd0);

        // DONE holds its result until out_ready.
        @(negedge clk);
        in_valid = 1'b1; op = 5'd0; src1 = 32'd3; src2 = 32'd4;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", out_valid, 1);
            check("hold_result", result, 32'd7);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("hold_released", out_valid, 0);

        // Flush in DONE drops out_valid even with out_ready asserted.
        @(negedge clk);
        in_valid = 1'b1; op = 5'd5; src1 = 32'hF0F0_F0F0; src2 = 32'h0FF0_0FF0;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b0;
        check("flush_done_valid", out_valid, 0);
        check("flush_done_ready", in_ready, 1);

        // Flush in IDLE suppresses acceptance.
        @(negedge clk);
        in_valid = 1'b1; op = 5'd22; src1 = 32'hDEAD_BEEF; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flush_idle_no_accept", out_valid, 0);
        exec_check("mfhi_flush_idle", 5'd20, 32'd0, 32'd0);

        // in_valid held during BUSY must be ignored.
        model(5'd16, 32'h0001_0003, 32'hFFFF_FFF7, a);
        @(negedge clk);
        in_valid = 1'b1; op = 5'd16; src1 = 32'h0001_0003; src2 = 32'hFFFF_FFF7;
        @(negedge clk);
        op = 5'd22; src1 = 32'h5A5A_5A5A;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check("busy_ignore_result", result, a);
        check("busy_ignore_latency", lat, 33);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exec_check("mfhi_busy_ignore", 5'd20, 32'd0, 32'd0);

        // Reset asserted mid-multiply.
        exec_check("pre_reset_add", 5'd0, 32'd1, 32'd1);
        @(negedge clk);
        in_valid = 1'b1; op = 5'd16; src1 = 32'd77; src2 = 32'd99;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_result", result, 0);
        check("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        resetn = 1'b1;
        m_hi = '0;
        m_lo = '0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", in_ready, 1);
        exec_check("mfhi_post_rst", 5'd20, 32'd0, 32'd0);
        exec_check("mflo_post_rst", 5'd21, 32'd0, 32'd0);

        // 8-bit instance: unsigned 0xFF * 0xFF.
        run_op8(5'd17, 8'hFF, 8'hFF, r8, lat);
        check("w8_multu_result", r8, 8'h01);
        check("w8_multu_latency", lat, 9);
        $display("w8 op=17 src1=0xff src2=0xff result=0x%02h latency=%0d", r8, lat);
        run_op8(5'd20, 8'h00, 8'h00, r8, lat);
        check("w8_mfhi", r8, 8'hFE);
        run_op8(5'd21, 8'h00, 8'h00, r8, lat);
        check("w8_mflo", r8, 8'h01);

        for (int n = 0; n < 80; n++) begin
            o = 5'($urandom_range(0, 31));
            a = rnd_val();
            b = rnd_val();
            exec_check("random", o, a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
